psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Downstream consumer of the output FIFO in the corelet datapath: pops one `col`-lane partial-sum vector per output pixel and read-modify-writes it into PMEM SRAM, accumulating across the `num_kij` kernel-offset passes. One `start` runs one kij pass of `len_onij` vectors. On the final pass it optionally applies ReLU, so PMEM ends up holding final outputs. It is instantiated beside the corelet FSM, which issues `start` and waits for `done` in its SFU phase.

## Interface
- `col`, 8, lanes per vector
- `psum_bw`, 16, signed width of each lane
- `len_onij`, 16, vectors (output pixels) per kij pass
- `num_kij`, 9, kij passes per full accumulation
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `start`  in  1  begin one pass; sampled only in IDLE
- `kij_idx`  in  4  pass index; sampled with `start`
- `relu_en`  in  1  apply ReLU on pass `num_kij-1`; sampled with `start`
- `out_base`  in  9  PMEM base address; sampled with `start`
- `ofifo_valid`  in  1  OFIFO head vector available
- `ofifo_out`  in  col*psum_bw  OFIFO head vector; lane c at bits [c*psum_bw +: psum_bw]
- `ofifo_rd`  out  1  pop OFIFO head this cycle
- `pmem_q`  in  col*psum_bw  SRAM read data, valid 1 cycle after a read
- `pmem_d`  out  col*psum_bw  SRAM write data, same lane packing
- `pmem_addr`  out  9  SRAM address
- `pmem_cen`  out  1  SRAM chip enable, active-low
- `pmem_wen`  out  1  SRAM write enable, active-low (1 = read)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a pass

## Operation
- **States:** IDLE, FETCH, ACC, DONE.
- **IDLE:**
  - On `start=1`, latch `kij_idx`, `relu_en` and `out_base`, clear vector counter `cnt`, and go to FETCH.
  - A `start` seen outside IDLE is ignored.
- **FETCH:**
  - Wait while `ofifo_valid=0`; outputs stay idle-valued and `cnt` holds.
  - When `ofifo_valid=1`: assert `ofifo_rd` (combinational, the same cycle), register `ofifo_out` into `fbuf`, and drive a PMEM read (`cen=0`, `wen=1`, `addr=out_base+cnt`). Then go to ACC.
  - The read is issued even when kij=0; its data is discarded.
- **ACC:**
  - Per lane, form `sum = sext(fbuf[c]) + sext(old[c])` at psum_bw+1 bits. `old` is `pmem_q`, or 0 when the latched kij=0.
  - Saturate `sum` to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - If latched kij = `num_kij-1` and `relu_en=1`, clamp negative lanes to 0 after saturation.
  - Drive the write: `cen=0`, `wen=0`, `addr=out_base+cnt`, `d=result`.
  - If `cnt=len_onij-1`, go to DONE; otherwise increment `cnt` and go to FETCH.
- **DONE:** `done=1` for this cycle only, then go to IDLE.
- **Address arithmetic:** `out_base+cnt` is taken modulo 2^9. Wrap past 511 returns to 0 with no error.
- **Outputs outside read/write cycles:** `pmem_cen=1`, `pmem_wen=1`, `pmem_addr=0`, `pmem_d=0`, `ofifo_rd=0`.
- **Reset:** asserting `reset` at any time (including mid-pass) forces IDLE and clears `cnt`, `fbuf` and the latched inputs. PMEM contents are not touched; a partially accumulated pass stays in PMEM, and the controller re-runs from kij=0.

## Timing
- Reset values: `ofifo_rd=0`, `pmem_cen=1`, `pmem_wen=1`, `pmem_addr=0`, `pmem_d=0`, `busy=0`, `done=0`.
- **Throughput:** 2 cycles per vector when `ofifo_valid` stays high.
- **Pass latency:** `start` sampled at cycle 0 gives FETCH at cycle 1 and the first write at cycle 2. The last write is at cycle 2·len_onij (cycle 32 for the defaults), `done` is high at cycle 2·len_onij+1, and IDLE returns at cycle 2·len_onij+2.
- **Stalls:** each FETCH cycle with `ofifo_valid=0` adds exactly one cycle. No vector is dropped or duplicated.
- **One pop per vector:** `ofifo_rd` is never high on two consecutive cycles.
- **Write–read interlock:** a PMEM write and the next read are never issued in the same cycle.

## Test plan
- **Init pass:** kij=0, `out_base=0`, 16 vectors with every lane = n (n = 0..15), `ofifo_valid` always high. Expect PMEM[n] lanes = n, `done` at cycle 33, and exactly 16 `ofifo_rd` pulses.
- **Accumulation:** run kij=0..8 with every lane = 1 and `relu_en=0`. Expect every PMEM[0..15] lane = 9 and 9 `done` pulses.
- **Saturation and ReLU:** PMEM lane = 32000 plus input 1000 gives 32767. On kij=8 with `relu_en=1`, an accumulated -5 gives 0 and +5 stays 5. With `relu_en=0`, -5 stays -5.
- **Stall:** hold `ofifo_valid` low for 3 cycles before vector 4. Expect no `ofifo_rd` and no PMEM access during the stall, correct data afterwards, and `done` 3 cycles later than the unstalled run.
- **Address wrap:** `out_base=505`, 16 vectors. Expect writes to addresses 505..511 then 0..8.
- **Mid-pass reset:** assert `reset` during ACC of vector 7. Expect all outputs at reset values immediately, PMEM[0..6] written and PMEM[7..15] untouched. A `start` issued after release runs a full pass normally.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: pops one partial-sum vector per output pixel from the OFIFO,
// adds it to the matching PMEM entry (or to zero on the first kij pass) with
// per-lane saturation, optionally applies ReLU on the last pass, and writes
// the result back. One start runs one kij pass of len_onij vectors.
module psum_accumulator #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int len_onij = 16,
    parameter int num_kij  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               kij_idx,
    input  logic                     relu_en,
    input  logic [8:0]               out_base,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   pmem_q,
    output logic [col*psum_bw-1:0]   pmem_d,
    output logic [8:0]               pmem_addr,
    output logic                     pmem_cen,
    output logic                     pmem_wen,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = (len_onij > 1) ? $clog2(len_onij) : 1;
    localparam int VEC_W = col * psum_bw;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ACC   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [VEC_W-1:0] fbuf_reg;
    logic [3:0]       kij_reg;
    logic             relu_reg;
    logic [8:0]       base_reg;

    logic [8:0]       addr_cur;
    logic             first_pass;
    logic             relu_active;
    logic [VEC_W-1:0] acc_result;

    // PMEM address wraps naturally at 9 bits.
    assign addr_cur    = base_reg + 9'(cnt_reg);
    // On the first pass the stale PMEM contents are ignored.
    assign first_pass  = (kij_reg == 4'd0);
    assign relu_active = relu_reg && (kij_reg == 4'(num_kij - 1));

    genvar gi;
    generate
        for (gi = 0; gi < col; gi = gi + 1) begin : g_lane
            logic [psum_bw-1:0] new_lane;
            logic [psum_bw-1:0] old_lane;
            logic [psum_bw:0]   sum_lane;
            logic [psum_bw-1:0] res_lane;

            assign new_lane = fbuf_reg[gi*psum_bw +: psum_bw];
            assign old_lane = first_pass ? '0 : pmem_q[gi*psum_bw +: psum_bw];
            assign sum_lane = {new_lane[psum_bw-1], new_lane} + {old_lane[psum_bw-1], old_lane};

            // Saturate the widened sum back to psum_bw, then clamp negatives on the final ReLU pass.
            always_comb begin
                if (sum_lane[psum_bw] != sum_lane[psum_bw-1]) begin
                    res_lane = sum_lane[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                                 : {1'b0, {(psum_bw-1){1'b1}}};
                end else begin
                    res_lane = sum_lane[psum_bw-1:0];
                end
                if (relu_active && res_lane[psum_bw-1]) begin
                    res_lane = '0;
                end
            end

            assign acc_result[gi*psum_bw +: psum_bw] = res_lane;
        end
    endgenerate

    // Pass control FSM: latch the pass parameters, then alternate FETCH/ACC per vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            fbuf_reg  <= '0;
            kij_reg   <= '0;
            relu_reg  <= 1'b0;
            base_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        kij_reg   <= kij_idx;
                        relu_reg  <= relu_en;
                        base_reg  <= out_base;
                        cnt_reg   <= '0;
                        state_reg <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ofifo_valid) begin
                        fbuf_reg  <= ofifo_out;
                        state_reg <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (cnt_reg == CNT_W'(len_onij - 1)) begin
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        state_reg <= S_FETCH;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Memory/FIFO strobes: read+pop in a productive FETCH cycle, write in ACC, idle values otherwise.
    always_comb begin
        ofifo_rd  = 1'b0;
        pmem_cen  = 1'b1;
        pmem_wen  = 1'b1;
        pmem_addr = '0;
        pmem_d    = '0;
        case (state_reg)
            S_FETCH: begin
                if (ofifo_valid) begin
                    ofifo_rd  = 1'b1;
                    pmem_cen  = 1'b0;
                    pmem_addr = addr_cur;
                end
            end
            S_ACC: begin
                pmem_cen  = 1'b0;
                pmem_wen  = 1'b0;
                pmem_addr = addr_cur;
                pmem_d    = acc_result;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: behavioural PMEM and OFIFO around the DUT,
// hand-computed expected PMEM contents, timing and address sequences.
module tb_psum_accumulator;

    localparam int COL = 8;
    localparam int PB  = 16;
    localparam int LEN = 16;
    localparam int NK  = 9;
    localparam int W   = COL * PB;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   kij_idx = '0;
    logic         relu_en = 1'b0;
    logic [8:0]   out_base = '0;
    logic         ofifo_valid = 1'b0;
    logic [W-1:0] ofifo_out;
    logic         ofifo_rd;
    logic [W-1:0] pmem_q;
    logic [W-1:0] pmem_d;
    logic [8:0]   pmem_addr;
    logic         pmem_cen;
    logic         pmem_wen;
    logic         busy;
    logic         done;

    logic [W-1:0] mem [0:511];
    logic [W-1:0] fifo_data [0:15];
    int           fi;

    int n_chk = 0;
    int n_bad = 0;

    // results of the most recent pass
    int done_cyc;
    int pops;
    int nw;
    int wr_addr [0:31];
    int dup_rd;
    int stall_viol;
    int idle_after;

    psum_accumulator #(.col(COL), .psum_bw(PB), .len_onij(LEN), .num_kij(NK)) dut (
        .clk(clk), .reset(reset), .start(start), .kij_idx(kij_idx), .relu_en(relu_en),
        .out_base(out_base), .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out),
        .ofifo_rd(ofifo_rd), .pmem_q(pmem_q), .pmem_d(pmem_d), .pmem_addr(pmem_addr),
        .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign ofifo_out = (fi < 16) ? fifo_data[fi[3:0]] : '0;

    // single-port SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (!pmem_cen) begin
            if (!pmem_wen) mem[pmem_addr] <= pmem_d;
            else           pmem_q <= mem[pmem_addr];
        end
    end

    function automatic logic [W-1:0] rep(input int v);
        logic [PB-1:0] l;
        l = v[PB-1:0];
        return {COL{l}};
    endfunction

    // even lanes get va, odd lanes get vb
    function automatic logic [W-1:0] alt(input int va, input int vb);
        logic [W-1:0] r;
        logic [PB-1:0] la;
        logic [PB-1:0] lb;
        la = va[PB-1:0];
        lb = vb[PB-1:0];
        for (int c = 0; c < COL; c++) r[c*PB +: PB] = (c % 2 == 0) ? la : lb;
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ofifo_rd"},  W'(ofifo_rd),  W'(0));
        check({tag, " pmem_cen"},  W'(pmem_cen),  W'(1));
        check({tag, " pmem_wen"},  W'(pmem_wen),  W'(1));
        check({tag, " pmem_addr"}, W'(pmem_addr), W'(0));
        check({tag, " pmem_d"},    pmem_d,        W'(0));
        check({tag, " busy"},      W'(busy),      W'(0));
        check({tag, " done"},      W'(done),      W'(0));
    endtask

    // Runs one pass. Period 0 is the cycle with start high; the loop variable
    // cyc is the index of the current period. stall_from<0 means no stall,
    // rst_at<0 means no mid-pass reset.
    task automatic run_pass(input int kij, input bit relu, input int base,
                            input int stall_from, input int stall_len, input int rst_at);
        bit pend;
        bit prev_rd;
        bit fin;
        done_cyc = -1; pops = 0; nw = 0; dup_rd = 0; stall_viol = 0; idle_after = 0;
        fi = 0; pend = 0; prev_rd = 0; fin = 0;
        @(negedge clk);
        start = 1'b1; kij_idx = kij[3:0]; relu_en = relu; out_base = base[8:0]; ofifo_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
            if (pend) fi++;
            pend = 0;
            ofifo_valid = !(stall_from >= 0 && cyc >= stall_from && cyc < stall_from + stall_len);
            #1;
            if (done_cyc >= 0) begin
                idle_after = (busy == 1'b0) ? 1 : 0;
                fin = 1;
            end else begin
                if (ofifo_rd) begin
                    pops++;
                    pend = 1;
                    if (prev_rd) dup_rd++;
                end
                prev_rd = ofifo_rd;
                if (!pmem_cen && !pmem_wen && nw < 32) begin
                    wr_addr[nw] = int'(pmem_addr);
                    nw++;
                end
                if (!ofifo_valid && (ofifo_rd || !pmem_cen)) stall_viol++;
                if (done) done_cyc = cyc;
                if (cyc == rst_at) begin
                    reset = 1'b0;
                    #1;
                    check_reset_outputs("midreset");
                    @(negedge clk);
                    @(negedge clk);
                    reset = 1'b1;
                    fin = 1;
                end
            end
            if (!fin) @(negedge clk);
        end
        ofifo_valid = 1'b0;
    endtask

    int dones;

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = '0;
        for (int n = 0; n < 16; n++) fifo_data[n] = '0;
        fi = 0;

        // reset state
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // init pass: kij=0, lanes = n
        for (int n = 0; n < 16; n++) fifo_data[n] = rep(n);
        run_pass(0, 0, 0, -1, 0, -1);
        check("init done_cyc", W'(done_cyc), W'(33));
        check("init pops", W'(pops), W'(16));
        check("init dup_rd", W'(dup_rd), W'(0));
        check("init idle_after", W'(idle_after), W'(1));
        check("init nw", W'(nw), W'(16));
        for (int n = 0; n < 16; n++) begin
            check($sformatf("init addr%0d", n), W'(wr_addr[n]), W'(n));
            check($sformatf("init mem%0d", n), mem[n], rep(n));
        end

        // accumulation over kij=0..8 with all lanes = 1
        for (int n = 0; n < 16; n++) fifo_data[n] = rep(1);
        dones = 0;
        for (int k = 0; k < NK; k++) begin
            run_pass(k, 0, 0, -1, 0, -1);
            if (done_cyc == 33) dones++;
        end
        check("accum dones", W'(dones), W'(9));
        for (int n = 0; n < 16; n++) check($sformatf("accum mem%0d", n), mem[n], rep(9));

        // saturation and ReLU on the last pass
        for (int n = 0; n < 16; n++) begin
            fifo_data[n] = '0;
            mem[n] = '0;
        end
        fifo_data[0] = rep(1000);  mem[0] = rep(32000);
        fifo_data[1] = rep(5);     mem[1] = rep(-10);
        fifo_data[2] = rep(5);     mem[2] = rep(0);
        fifo_data[3] = rep(-1000); mem[3] = rep(-32000);
        fifo_data[4] = rep(5);     mem[4] = alt(-10, 0);
        run_pass(8, 1, 0, -1, 0, -1);
        check("relu1 sat_pos", mem[0], rep(32767));
        check("relu1 neg5", mem[1], rep(0));
        check("relu1 pos5", mem[2], rep(5));
        check("relu1 sat_neg", mem[3], rep(0));
        check("relu1 mixed", mem[4], alt(0, 5));
        check("relu1 zero", mem[5], rep(0));

        mem[0] = rep(32000); mem[1] = rep(-10); mem[2] = rep(0);
        mem[3] = rep(-32000); mem[4] = alt(-10, 0);
        run_pass(8, 0, 0, -1, 0, -1);
        check("relu0 sat_pos", mem[0], rep(32767));
        check("relu0 neg5", mem[1], rep(-5));
        check("relu0 pos5", mem[2], rep(5));
        check("relu0 sat_neg", mem[3], rep(-32768));
        check("relu0 mixed", mem[4], alt(-5, 5));

        mem[1] = rep(-10);
        run_pass(3, 1, 0, -1, 0, -1);
        check("relu_notlast neg5", mem[1], rep(-5));

        // stall before vector 4 (its FETCH is period 9)
        for (int n = 0; n < 16; n++) fifo_data[n] = rep(n + 20);
        run_pass(0, 0, 0, 9, 3, -1);
        check("stall done_cyc", W'(done_cyc), W'(36));
        check("stall viol", W'(stall_viol), W'(0));
        check("stall pops", W'(pops), W'(16));
        check("stall dup_rd", W'(dup_rd), W'(0));
        for (int n = 0; n < 16; n++) check($sformatf("stall mem%0d", n), mem[n], rep(n + 20));

        // address wrap from 505
        for (int n = 0; n < 16; n++) fifo_data[n] = rep(n + 40);
        run_pass(0, 0, 505, -1, 0, -1);
        check("wrap nw", W'(nw), W'(16));
        for (int n = 0; n < 16; n++) begin
            check($sformatf("wrap addr%0d", n), W'(wr_addr[n]), W'((505 + n) % 512));
            check($sformatf("wrap mem%0d", n), mem[(505 + n) % 512], rep(n + 40));
        end

        // reset during ACC of vector 7 (period 16)
        for (int n = 0; n < 16; n++) begin
            mem[n] = rep(23130);
            fifo_data[n] = rep(n + 60);
        end
        run_pass(0, 0, 0, -1, 0, 16);
        for (int n = 0; n < 16; n++)
            check($sformatf("midreset mem%0d", n), mem[n], (n < 7) ? rep(n + 60) : rep(23130));
        run_pass(0, 0, 0, -1, 0, -1);
        check("after_reset done_cyc", W'(done_cyc), W'(33));
        check("after_reset pops", W'(pops), W'(16));
        for (int n = 0; n < 16; n++) check($sformatf("after_reset mem%0d", n), mem[n], rep(n + 60));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
